// File: rtl/ota_ctrl_pkg.sv
// Shared definitions for the OTA trim calibration controller: the sequencer
// state type, vote/settle constants and the trim-DAC midcode helper.
package ota_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Shortest settle wait; covers the two-flop comparator synchronizer.
    localparam int MIN_SETTLE = 2;

    // Comparator samples taken per SAR bit (majority voted).
    localparam int NUM_VOTES = 3;

    // Midcode of a w-bit trim DAC: MSB set, all other bits clear.
    function automatic int unsigned midcode(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous analog-return nets (comparator
// outputs and similar). Both flops clear on reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Double-register the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/ota_trim_cal_ctrl.sv
// OTA offset calibration sequencer. Enables the OTA, shorts its inputs and
// runs a SAR search on the trim-DAC code using majority-voted comparator
// samples taken after a programmable settle time. The finished code is held
// on trim_out with trim_valid; abort restores the last good result.
//
// Control protocol: start is a one-cycle request honoured only in IDLE and
// ignored when abort is high in the same cycle; abort ends any busy state
// except DONE; done pulses for exactly one cycle when a run completes.
module ota_trim_cal_ctrl
    import ota_ctrl_pkg::*;
#(
    parameter int TRIM_W   = 6,
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                cmp_in,
    output logic                ota_en,
    output logic                cal_short,
    output logic [TRIM_W-1:0]   trim_out,
    output logic                busy,
    output logic                done,
    output logic                trim_valid,
    output logic                err,
    output logic [2:0]          dbg_state
);

    localparam int                IDX_W     = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] MIDCODE   = TRIM_W'(midcode(TRIM_W));
    localparam logic [1:0]        VOTE_LAST = 2'(NUM_VOTES - 1);

    state_t              r_state;
    logic [SETTLE_W-1:0] r_settle_len;
    logic [SETTLE_W-1:0] r_cnt;
    logic [1:0]          r_vcnt;
    logic [2:0]          r_votes;
    logic [IDX_W-1:0]    r_idx;
    logic [TRIM_W-1:0]   r_work;
    logic [TRIM_W-1:0]   r_last_good;
    logic                r_valid_saved;
    logic                r_ota_en;
    logic                r_cal_short;
    logic [TRIM_W-1:0]   r_trim;
    logic                r_done;
    logic                r_trim_valid;
    logic                r_err;

    logic                w_cmp_s;
    logic                w_vote;
    logic                w_busy_abortable;
    logic [SETTLE_W-1:0] w_settle_clamped;
    logic [TRIM_W-1:0]   w_next_work;

    sync2 u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (w_cmp_s)
    );

    assign w_vote = (r_votes[0] & r_votes[1]) |
                    (r_votes[0] & r_votes[2]) |
                    (r_votes[1] & r_votes[2]);

    assign w_settle_clamped = (settle_cycles < SETTLE_W'(MIN_SETTLE)) ?
                              SETTLE_W'(MIN_SETTLE) : settle_cycles;

    // DONE is deliberately not abortable so a finished result always lands.
    assign w_busy_abortable = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE) ||
                              (r_state == ST_DECIDE);

    // SAR step: drop the bit under test if the comparator says "too high",
    // then trial-set the next lower bit.
    always_comb begin
        w_next_work = r_work;
        if (w_vote) begin
            w_next_work[r_idx] = 1'b0;
        end
        if (r_idx != '0) begin
            w_next_work[r_idx - 1'b1] = 1'b1;
        end
    end

    // Calibration sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_settle_len  <= SETTLE_W'(MIN_SETTLE);
            r_cnt         <= '0;
            r_vcnt        <= '0;
            r_votes       <= '0;
            r_idx         <= '0;
            r_work        <= MIDCODE;
            r_last_good   <= MIDCODE;
            r_valid_saved <= 1'b0;
            r_ota_en      <= 1'b0;
            r_cal_short   <= 1'b0;
            r_trim        <= MIDCODE;
            r_done        <= 1'b0;
            r_trim_valid  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && w_busy_abortable) begin
                r_state      <= ST_IDLE;
                r_cal_short  <= 1'b0;
                r_trim       <= r_last_good;
                r_trim_valid <= r_valid_saved;
                r_ota_en     <= r_valid_saved;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_state       <= ST_SETTLE;
                            r_settle_len  <= w_settle_clamped;
                            r_cnt         <= '0;
                            r_work        <= MIDCODE;
                            r_trim        <= MIDCODE;
                            r_idx         <= IDX_W'(TRIM_W - 1);
                            r_err         <= 1'b0;
                            r_valid_saved <= r_trim_valid;
                            r_trim_valid  <= 1'b0;
                            r_ota_en      <= 1'b1;
                            r_cal_short   <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_cnt == r_settle_len - 1'b1) begin
                            r_state <= ST_SAMPLE;
                            r_cnt   <= '0;
                            r_vcnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        r_votes <= {r_votes[1:0], w_cmp_s};
                        if (r_vcnt == VOTE_LAST) begin
                            r_state <= ST_DECIDE;
                            r_vcnt  <= '0;
                        end else begin
                            r_vcnt <= r_vcnt + 1'b1;
                        end
                    end
                    ST_DECIDE: begin
                        r_work <= w_next_work;
                        r_trim <= w_next_work;
                        if (r_idx == '0) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_trim_valid <= 1'b1;
                            r_last_good  <= w_next_work;
                            r_cal_short  <= 1'b0;
                            r_err        <= (w_next_work == '0) ||
                                            (w_next_work == {TRIM_W{1'b1}});
                        end else begin
                            r_state <= ST_SETTLE;
                            r_idx   <= r_idx - 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ota_en     = r_ota_en;
    assign cal_short  = r_cal_short;
    assign trim_out   = r_trim;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign trim_valid = r_trim_valid;
    assign err        = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ota_trim_cal_ctrl.sv
// Bench for ota_trim_cal_ctrl: a comparator model with a fixed threshold K,
// table-driven calibration runs and directed abort/reset sequences.
module tb_ota_trim_cal_ctrl;

    localparam int TRIM_W   = 6;
    localparam int SETTLE_W = 8;
    localparam int MAXCODE  = (1 << TRIM_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                cmp_in;
    logic                ota_en;
    logic                cal_short;
    logic [TRIM_W-1:0]   trim_out;
    logic                busy;
    logic                done;
    logic                trim_valid;
    logic                err;
    logic [2:0]          dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Comparator model state
    int k_val     = 64;
    bit glitch_en = 1'b0;
    int t_start   = 0;
    int s_eff     = 2;
    int g_off;
    int g_bit;

    typedef struct {
        int k;
        int settle;
        bit glitch;
        bit poke;
        int exp_code;
        bit exp_err;
        int exp_lat;
    } vec_t;

    vec_t vecs[14];

    ota_trim_cal_ctrl #(.TRIM_W(TRIM_W), .SETTLE_W(SETTLE_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .settle_cycles (settle_cycles),
        .cmp_in        (cmp_in),
        .ota_en        (ota_en),
        .cal_short     (cal_short),
        .trim_out      (trim_out),
        .busy          (busy),
        .done          (done),
        .trim_valid    (trim_valid),
        .err           (err),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal comparator: high when trim_out >= K. In glitch mode one cmp_in
    // cycle per bit is inverted, positioned (after the 2-cycle synchronizer)
    // on sample 0, 1 or 2 of that bit in rotation.
    always_comb begin
        g_off  = 0;
        g_bit  = 0;
        cmp_in = (int'(trim_out) >= k_val);
        if (glitch_en && (cyc > t_start)) begin
            g_off = (cyc - t_start - 1) % (s_eff + 4);
            g_bit = (cyc - t_start - 1) / (s_eff + 4);
            if (g_off == (s_eff - 2 + (g_bit % 3))) begin
                cmp_in = ~cmp_in;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the SAR converges on the largest code below K, saturating
    // at the rails.
    function automatic int model_code(input int k);
        if (k <= 0) return 0;
        if (k - 1 > MAXCODE) return MAXCODE;
        return k - 1;
    endfunction

    function automatic vec_t mk_vec(input int k, input int settle, input bit g,
                                    input bit poke);
        vec_t v;
        int   s;
        s          = (settle < 2) ? 2 : settle;
        v.k        = k;
        v.settle   = settle;
        v.glitch   = g;
        v.poke     = poke;
        v.exp_code = model_code(k);
        v.exp_err  = (v.exp_code == 0) || (v.exp_code == MAXCODE);
        v.exp_lat  = TRIM_W * (s + 4) + 1;
        return v;
    endfunction

    function automatic vec_t lit_vec(input int k, input int settle, input bit g,
                                     input bit poke, input int code, input bit e,
                                     input int lat);
        vec_t v;
        v.k        = k;
        v.settle   = settle;
        v.glitch   = g;
        v.poke     = poke;
        v.exp_code = code;
        v.exp_err  = e;
        v.exp_lat  = lat;
        return v;
    endfunction

    // Issues start, then waits (bounded) for done. Returns at the negedge of
    // the done cycle. Optionally pokes start mid-run and always scrambles
    // settle_cycles after the start cycle.
    task automatic run_cal(input int k, input int settle, input bit g, input bit poke,
                           output int lat, output bit timed_out);
        @(negedge clk);
        k_val         = k;
        glitch_en     = g;
        s_eff         = (settle < 2) ? 2 : settle;
        settle_cycles = SETTLE_W'(settle);
        start         = 1'b1;
        t_start       = cyc;
        @(negedge clk);
        start         = 1'b0;
        settle_cycles = SETTLE_W'($urandom_range(0, 255));
        lat           = -1;
        timed_out     = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                lat       = cyc - t_start;
                timed_out = 1'b0;
                break;
            end
            start = (poke && (i == 10));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        bit tmo;
        int n_done;
        int target;
        bit prev_short;
        vec_t v;

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        settle_cycles = '0;

        // Directed rows from the test plan, then randomized rows from the model.
        vecs[0] = lit_vec(37, 4, 1'b0, 1'b0, 36, 1'b0, 49);
        vecs[1] = lit_vec(0,  4, 1'b0, 1'b0, 0,  1'b1, 49);
        vecs[2] = lit_vec(64, 4, 1'b0, 1'b0, 63, 1'b1, 49);
        vecs[3] = lit_vec(37, 0, 1'b0, 1'b0, 36, 1'b0, 37);
        vecs[4] = lit_vec(20, 4, 1'b1, 1'b0, 19, 1'b0, 49);
        vecs[5] = lit_vec(37, 4, 1'b0, 1'b1, 36, 1'b0, 49);
        for (int i = 6; i < 14; i++) begin
            vecs[i] = mk_vec($urandom_range(0, 64), $urandom_range(0, 10),
                             1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_trim_out", trim_out, 32);
        check("reset_trim_valid", trim_valid, 0);
        check("reset_ota_en", ota_en, 0);
        check("reset_busy", busy, 0);
        check("reset_cal_short", cal_short, 0);
        check("reset_err", err, 0);
        check("reset_done", done, 0);

        // Table-driven calibration runs
        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            run_cal(v.k, v.settle, v.glitch, v.poke, lat, tmo);
            check($sformatf("v%0d_timeout", i), tmo, 0);
            check($sformatf("v%0d_latency", i), lat, v.exp_lat);
            check($sformatf("v%0d_trim_out", i), trim_out, v.exp_code);
            check($sformatf("v%0d_err", i), err, v.exp_err);
            check($sformatf("v%0d_valid_at_done", i), trim_valid, 1);
            check($sformatf("v%0d_cal_short_at_done", i), cal_short, 0);
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", i), busy, 0);
            check($sformatf("v%0d_idle_done", i), done, 0);
            check($sformatf("v%0d_idle_ota_en", i), ota_en, 1);
            check($sformatf("v%0d_idle_trim_out", i), trim_out, v.exp_code);
            glitch_en = 1'b0;
        end

        // Fresh valid result of 36, with cal_short watched across done.
        @(negedge clk);
        k_val = 37; settle_cycles = 8'd4; start = 1'b1; t_start = cyc; s_eff = 4;
        @(negedge clk);
        start      = 1'b0;
        check("cal_short_during_run", cal_short, 1);
        prev_short = 1'b0;
        tmo        = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                tmo = 1'b0;
                break;
            end
            prev_short = cal_short;
            @(negedge clk);
        end
        check("fall_timeout", tmo, 0);
        check("cal_short_before_done", prev_short, 1);
        check("cal_short_with_done", cal_short, 0);
        check("fall_trim_out", trim_out, 36);

        // Abort in the third SETTLE, with a start poke while busy.
        @(negedge clk);
        k_val = 10; settle_cycles = 8'd4; start = 1'b1; t_start = cyc; s_eff = 4;
        @(negedge clk);
        start  = 1'b0;
        target = t_start + 1 + 2 * (4 + 4) + 1;
        tmo    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cyc == target) begin
                tmo = 1'b0;
                break;
            end
            start = (i == 5);
            @(negedge clk);
        end
        start = 1'b0;
        check("abort_reach_timeout", tmo, 0);
        check("abort_pre_busy", busy, 1);
        check("abort_pre_state_settle", dbg_state, 1);
        check("abort_pre_valid", trim_valid, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_trim_out", trim_out, 36);
        check("abort_trim_valid", trim_valid, 1);
        check("abort_done", done, 0);
        check("abort_cal_short", cal_short, 0);
        check("abort_ota_en", ota_en, 1);
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done_pulse", n_done, 0);
        check("abort_stays_idle", busy, 0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        check("start_abort_idle_valid", trim_valid, 1);
        @(negedge clk);
        check("start_abort_idle_busy2", busy, 0);

        // abort during DONE is ignored.
        run_cal(45, 3, 1'b0, 1'b0, lat, tmo);
        check("done_abort_timeout", tmo, 0);
        check("done_abort_latency", lat, 6 * 7 + 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("done_abort_valid", trim_valid, 1);
        check("done_abort_trim_out", trim_out, 44);
        check("done_abort_busy", busy, 0);

        // Reset mid-run returns everything to reset values.
        @(negedge clk);
        k_val = 37; settle_cycles = 8'd4; start = 1'b1; t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_pre_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_trim_out", trim_out, 32);
        check("rst_trim_valid", trim_valid, 0);
        check("rst_ota_en", ota_en, 0);
        check("rst_cal_short", cal_short, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ota_trim_cal_ctrl.md
Name: ota_trim_cal_ctrl

Overview:
Sequencer that calibrates the input offset of the gate-level digital OTA/comparator.
- Enables the OTA and shorts its inputs through the calibration switch.
- Runs a SAR binary search on the OTA trim-DAC code, using majority-voted comparator samples after a programmable settle time.
- Publishes the final trim code with a valid flag.
- Sits between the top-level control pins and the OTA trim/enable nets.

Parameters:
- TRIM_W, 6: trim-DAC code width (bits).
- SETTLE_W, 8: width of the settle-count input.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin calibration; honoured only in IDLE.
- abort  input  1  terminate calibration; return to IDLE.
- settle_cycles  input  SETTLE_W  OTA settle wait per bit; sampled on start.
- cmp_in  input  1  raw OTA output, asynchronous to clk.
- ota_en  output  1  OTA enable (drives the EN path).
- cal_short  output  1  shorts Vip/Vin for offset measurement.
- trim_out  output  TRIM_W  code driven to the trim DAC.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at completion.
- trim_valid  output  1  trim_out holds a completed calibration result.
- err  output  1  final code railed (all zeros or all ones); sticky until next start.

Behaviour:
Reset values:
- ota_en=0, cal_short=0, busy=0, done=0, trim_valid=0, err=0.
- trim_out = midcode (MSB=1, others 0); last_good register = midcode.
- State = IDLE; synchronizer flops = 0.

cmp_in synchronization:
- 2-flop synchronizer feeds cmp_s.
- Settle count is clamped to a minimum of 2 so that synchronizer latency is always covered.

States: IDLE, SETTLE, SAMPLE, DECIDE, DONE.
- IDLE:
  - ota_en=1 if trim_valid=1, else 0; cal_short=0.
  - On start (cycle T): latch S = max(settle_cycles, 2); work = midcode; idx = TRIM_W-1; err=0; trim_valid=0; go to SETTLE.
- SETTLE:
  - ota_en=1, cal_short=1, trim_out=work.
  - Counts S cycles, then goes to SAMPLE.
- SAMPLE:
  - Captures cmp_s on 3 consecutive cycles into v0..v2.
  - Then goes to DECIDE.
- DECIDE (1 cycle):
  - vote = majority(v0, v1, v2).
  - If vote=1, clear work[idx].
  - If idx=0, go to DONE.
  - Else decrement idx, set work[idx-1], go to SETTLE.
- DONE (1 cycle):
  - done=1, trim_valid=1, last_good=work.
  - err=1 if work == 0 or work == all ones.
  - cal_short=0; go to IDLE.

Output and timing rules:
- trim_out always equals work while busy; it holds the final value in IDLE.
- Latency: done is high at cycle T + TRIM_W*(S+4) + 1.

Boundary conditions:
- start while busy: ignored.
- start and abort in the same IDLE cycle: abort wins; stay in IDLE.
- abort in any busy state:
  - Next cycle is IDLE; cal_short=0; done is not pulsed.
  - trim_out = last_good; trim_valid is restored to its pre-start value.
- abort in the same cycle as DONE: DONE completes; abort is ignored.
- settle_cycles changing mid-run: no effect, because S is latched on start.
- rst mid-run: all registers return to their reset values on the next clock edge.

Decomposition:
- Shared package ota_ctrl_pkg holds:
  - the state enum type;
  - MIN_SETTLE=2 and NUM_VOTES=3;
  - a midcode function of TRIM_W.
- One natural sub-module, sync2: the 2-flop synchronizer for cmp_in, reused for other asynchronous analog-return nets.
- The SAR/FSM logic stays in the parent.

Test Plan (all with TRIM_W=6 and the model cmp_in = (trim_out >= K)):
- Reset, then idle: trim_out=6'b100000, trim_valid=0, ota_en=0, busy=0.
- K=37, settle_cycles=4, start at T -> done at T+49, trim_out=36, trim_valid=1, err=0, cal_short falls with done.
- K=0 (cmp always 1) -> trim_out=0, err=1. K=64 (cmp always 0) -> trim_out=63, err=1.
- settle_cycles=0 -> S clamped to 2; done at T+37; result for K=37 is still 36.
- Glitchy cmp: one sample of three inverted per bit, K=20 -> majority vote still yields trim_out=19.
- Abort injected during the third SETTLE after a prior valid result of 36:
  - Next cycle: IDLE, trim_out=36, trim_valid=1, no done pulse.
  - A start issued while busy has no effect.
